// File: rtl/intersection_phase_scheduler.sv
// Demand-driven two-axis intersection phase scheduler: min/max green, yellow,
// all-red clearance, latched pedestrian requests with walk, and preempt override.
module intersection_phase_scheduler #(
   parameter int MIN_GREEN    = 4,
   parameter int MAX_GREEN    = 10,
   parameter int YELLOW_TIME  = 2,
   parameter int ALL_RED_TIME = 1,
   parameter int WALK_TIME    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] veh_req,
   input  logic [1:0] ped_req,
   input  logic       preempt,
   output logic [1:0] ns_light,
   output logic [1:0] ew_light,
   output logic [1:0] walk,
   output logic [1:0] ped_pending,
   output logic       phase_start
);

   localparam int TW = $clog2(MAX_GREEN + 1);

   localparam logic [TW-1:0] TIMER_SAT = TW'(MAX_GREEN);
   localparam logic [TW:0]   MIN_T     = (TW+1)'(MIN_GREEN);
   localparam logic [TW:0]   MAX_T     = (TW+1)'(MAX_GREEN);
   localparam logic [TW:0]   YEL_T     = (TW+1)'(YELLOW_TIME);
   localparam logic [TW:0]   AR_T      = (TW+1)'(ALL_RED_TIME);
   localparam logic [TW:0]   WALK_T    = (TW+1)'(WALK_TIME);
   localparam logic [TW:0]   ONE       = {{TW{1'b0}}, 1'b1};

   localparam logic [1:0] LIGHT_RED    = 2'b00;
   localparam logic [1:0] LIGHT_YELLOW = 2'b01;
   localparam logic [1:0] LIGHT_GREEN  = 2'b10;

   typedef enum logic [1:0] {
      ST_ALL_RED = 2'd0,
      ST_GREEN   = 2'd1,
      ST_YELLOW  = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic          dir, dir_nx;
   logic          last_dir, last_dir_nx;
   logic [TW-1:0] timer, timer_nx;
   logic [TW:0]   timer_inc;
   logic [1:0]    demand;
   logic          green_entry;
   logic [1:0]    ns_nx, ew_nx, walk_nx, pending_nx;
   logic          phase_start_nx;

   // timer_inc compares as "timer >= N-1" without an always-true unsigned compare when N=1
   assign timer_inc = {1'b0, timer} + ONE;
   assign demand    = veh_req | ped_pending;

   always_comb begin
      state_nx    = state;
      dir_nx      = dir;
      last_dir_nx = last_dir;
      case (state)
         ST_ALL_RED: begin
            if (!preempt && (timer_inc >= AR_T) && (|demand)) begin
               state_nx = ST_GREEN;
               dir_nx   = (&demand) ? ~last_dir : demand[1];
            end
         end
         ST_GREEN: begin
            if (preempt ||
                ((timer_inc >= MIN_T) && !veh_req[dir] && demand[~dir]) ||
                ((timer_inc >= MAX_T) && demand[~dir]))
               state_nx = ST_YELLOW;
         end
         ST_YELLOW: begin
            if (timer_inc >= YEL_T) begin
               state_nx    = ST_ALL_RED;
               last_dir_nx = dir;
            end
         end
         default: begin
            state_nx = ST_ALL_RED;
         end
      endcase
   end

   // Preempt keeps the all-red timer at zero so a full clearance follows release.
   always_comb begin
      timer_nx = timer;
      if ((state_nx != state) || ((state == ST_ALL_RED) && preempt))
         timer_nx = '0;
      else if (timer < TIMER_SAT)
         timer_nx = timer_inc[TW-1:0];
   end

   assign green_entry = (state_nx == ST_GREEN) && (state != ST_GREEN);

   always_comb begin
      ns_nx          = LIGHT_RED;
      ew_nx          = LIGHT_RED;
      walk_nx        = 2'b00;
      pending_nx     = ped_pending | ped_req;
      phase_start_nx = green_entry;
      if (state_nx == ST_GREEN) begin
         if (dir_nx) ew_nx = LIGHT_GREEN;
         else        ns_nx = LIGHT_GREEN;
      end else if (state_nx == ST_YELLOW) begin
         if (dir_nx) ew_nx = LIGHT_YELLOW;
         else        ns_nx = LIGHT_YELLOW;
      end
      if (green_entry) begin
         walk_nx[dir_nx]    = ped_pending[dir_nx] | ped_req[dir_nx];
         pending_nx[dir_nx] = 1'b0;
      end else if ((state == ST_GREEN) && (state_nx == ST_GREEN)) begin
         walk_nx = (timer_inc < WALK_T) ? walk : 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_ALL_RED;
         dir         <= 1'b0;
         last_dir    <= 1'b1;
         timer       <= '0;
         ns_light    <= LIGHT_RED;
         ew_light    <= LIGHT_RED;
         walk        <= 2'b00;
         ped_pending <= 2'b00;
         phase_start <= 1'b0;
      end else begin
         state       <= state_nx;
         dir         <= dir_nx;
         last_dir    <= last_dir_nx;
         timer       <= timer_nx;
         ns_light    <= ns_nx;
         ew_light    <= ew_nx;
         walk        <= walk_nx;
         ped_pending <= pending_nx;
         phase_start <= phase_start_nx;
      end
   end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scenario bench for intersection_phase_scheduler: expected output vectors
// {ns, ew, walk, ped_pending, phase_start} are queued per cycle and compared.
module tb_intersection_phase_scheduler;

   localparam logic [1:0] R = 2'b00;
   localparam logic [1:0] Y = 2'b01;
   localparam logic [1:0] G = 2'b10;

   logic       clk;
   logic       reset;
   logic [1:0] veh_req;
   logic [1:0] ped_req;
   logic       preempt;
   logic [1:0] ns_light;
   logic [1:0] ew_light;
   logic [1:0] walk;
   logic [1:0] ped_pending;
   logic       phase_start;

   logic [8:0] exp_q[$];
   logic [8:0] got;
   logic [8:0] exp_v;
   int         checks   = 0;
   int         failures = 0;

   intersection_phase_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .veh_req     (veh_req),
      .ped_req     (ped_req),
      .preempt     (preempt),
      .ns_light    (ns_light),
      .ew_light    (ew_light),
      .walk        (walk),
      .ped_pending (ped_pending),
      .phase_start (phase_start)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [8:0] ev(input logic [1:0] ns, input logic [1:0] ew,
                                     input logic [1:0] wk, input logic [1:0] pp,
                                     input logic ps);
      return {ns, ew, wk, pp, ps};
   endfunction

   // Inputs change at the negedge, right after the previous sample.
   task automatic apply_reset();
      reset   = 1'b1;
      veh_req = 2'b00;
      ped_req = 2'b00;
      preempt = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 6; c++) begin
         reset   = (c < 2);
         veh_req = (c < 2) ? 2'b11 : 2'b00;
         ped_req = (c < 2) ? 2'b11 : 2'b00;
         preempt = 1'b0;
         exp_q.push_back(ev(R, R, 2'b00, 2'b00, 1'b0));
         @(negedge clk);
         got   = {ns_light, ew_light, walk, ped_pending, phase_start};
         exp_v = exp_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL reset c=%0d got=%b want=%b", c, got, exp_v);
         end
      end
   endtask

   task automatic test_idle_grant();
      for (int c = 0; c < 13; c++) begin
         veh_req = 2'b01;
         exp_q.push_back(ev(G, R, 2'b00, 2'b00, c == 0));
         @(negedge clk);
         got   = {ns_light, ew_light, walk, ped_pending, phase_start};
         exp_v = exp_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL idle_grant c=%0d got=%b want=%b", c, got, exp_v);
         end
      end
   endtask

   task automatic test_max_green();
      int p;
      logic [1:0] ns, ew;
      apply_reset();
      for (int c = 0; c < 53; c++) begin
         veh_req = 2'b11;
         p  = c % 26;
         ns = (p < 10) ? G : (p < 12) ? Y : R;
         ew = (p >= 13 && p < 23) ? G : (p >= 23 && p < 25) ? Y : R;
         exp_q.push_back(ev(ns, ew, 2'b00, 2'b00, (p == 0) || (p == 13)));
         @(negedge clk);
         got   = {ns_light, ew_light, walk, ped_pending, phase_start};
         exp_v = exp_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL max_green c=%0d got=%b want=%b", c, got, exp_v);
         end
      end
   endtask

   task automatic test_min_green();
      apply_reset();
      for (int c = 0; c < 11; c++) begin
         veh_req = (c == 0) ? 2'b01 : 2'b10;
         ped_req = (c == 7) ? 2'b10 : 2'b00;
         case (c)
            0:             exp_q.push_back(ev(G, R, 2'b00, 2'b00, 1'b1));
            1, 2, 3:       exp_q.push_back(ev(G, R, 2'b00, 2'b00, 1'b0));
            4, 5:          exp_q.push_back(ev(Y, R, 2'b00, 2'b00, 1'b0));
            6:             exp_q.push_back(ev(R, R, 2'b00, 2'b00, 1'b0));
            7:             exp_q.push_back(ev(R, G, 2'b10, 2'b00, 1'b1));
            8, 9:          exp_q.push_back(ev(R, G, 2'b10, 2'b00, 1'b0));
            default:       exp_q.push_back(ev(R, G, 2'b00, 2'b00, 1'b0));
         endcase
         @(negedge clk);
         got   = {ns_light, ew_light, walk, ped_pending, phase_start};
         exp_v = exp_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL min_green c=%0d got=%b want=%b", c, got, exp_v);
         end
      end
   endtask

   task automatic test_ped_walk();
      apply_reset();
      for (int c = 0; c < 23; c++) begin
         veh_req = 2'b01;
         ped_req = (c == 2) ? 2'b10 : (c == 21) ? 2'b01 : 2'b00;
         if (c == 0)                   exp_q.push_back(ev(G, R, 2'b00, 2'b00, 1'b1));
         else if (c == 1)              exp_q.push_back(ev(G, R, 2'b00, 2'b00, 1'b0));
         else if (c <= 9)              exp_q.push_back(ev(G, R, 2'b00, 2'b10, 1'b0));
         else if (c <= 11)             exp_q.push_back(ev(Y, R, 2'b00, 2'b10, 1'b0));
         else if (c == 12)             exp_q.push_back(ev(R, R, 2'b00, 2'b10, 1'b0));
         else if (c == 13)             exp_q.push_back(ev(R, G, 2'b10, 2'b00, 1'b1));
         else if (c <= 15)             exp_q.push_back(ev(R, G, 2'b10, 2'b00, 1'b0));
         else if (c == 16)             exp_q.push_back(ev(R, G, 2'b00, 2'b00, 1'b0));
         else if (c <= 18)             exp_q.push_back(ev(R, Y, 2'b00, 2'b00, 1'b0));
         else if (c == 19)             exp_q.push_back(ev(R, R, 2'b00, 2'b00, 1'b0));
         else if (c == 20)             exp_q.push_back(ev(G, R, 2'b00, 2'b00, 1'b1));
         else                          exp_q.push_back(ev(G, R, 2'b00, 2'b01, 1'b0));
         @(negedge clk);
         got   = {ns_light, ew_light, walk, ped_pending, phase_start};
         exp_v = exp_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL ped_walk c=%0d got=%b want=%b", c, got, exp_v);
         end
      end
   endtask

   task automatic test_preempt();
      apply_reset();
      for (int c = 0; c < 12; c++) begin
         veh_req = 2'b01;
         ped_req = (c == 0) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00;
         preempt = (c >= 2 && c <= 7);
         if (c == 0)       exp_q.push_back(ev(G, R, 2'b01, 2'b00, 1'b1));
         else if (c == 1)  exp_q.push_back(ev(G, R, 2'b01, 2'b10, 1'b0));
         else if (c <= 3)  exp_q.push_back(ev(Y, R, 2'b00, 2'b10, 1'b0));
         else if (c <= 7)  exp_q.push_back(ev(R, R, 2'b00, 2'b10, 1'b0));
         else if (c == 8)  exp_q.push_back(ev(R, G, 2'b10, 2'b00, 1'b1));
         else if (c <= 10) exp_q.push_back(ev(R, G, 2'b10, 2'b00, 1'b0));
         else              exp_q.push_back(ev(R, G, 2'b00, 2'b00, 1'b0));
         @(negedge clk);
         got   = {ns_light, ew_light, walk, ped_pending, phase_start};
         exp_v = exp_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL preempt c=%0d got=%b want=%b", c, got, exp_v);
         end
      end
      preempt = 1'b0;
   endtask

   task automatic test_reset_mid_phase();
      apply_reset();
      for (int c = 0; c < 8; c++) begin
         reset   = (c == 5);
         veh_req = (c == 0) ? 2'b10 : (c >= 6) ? 2'b11 : 2'b00;
         ped_req = (c == 1) ? 2'b01 : 2'b00;
         if (c == 0)       exp_q.push_back(ev(R, G, 2'b00, 2'b00, 1'b1));
         else if (c <= 3)  exp_q.push_back(ev(R, G, 2'b00, 2'b01, 1'b0));
         else if (c == 4)  exp_q.push_back(ev(R, Y, 2'b00, 2'b01, 1'b0));
         else if (c == 5)  exp_q.push_back(ev(R, R, 2'b00, 2'b00, 1'b0));
         else if (c == 6)  exp_q.push_back(ev(G, R, 2'b00, 2'b00, 1'b1));
         else              exp_q.push_back(ev(G, R, 2'b00, 2'b00, 1'b0));
         @(negedge clk);
         got   = {ns_light, ew_light, walk, ped_pending, phase_start};
         exp_v = exp_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            failures++;
            $display("FAIL reset_mid_phase c=%0d got=%b want=%b", c, got, exp_v);
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      veh_req = 2'b00;
      ped_req = 2'b00;
      preempt = 1'b0;
      test_reset();
      test_idle_grant();
      test_max_green();
      test_min_green();
      test_ped_walk();
      test_preempt();
      test_reset_mid_phase();
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
